lsu_mem_req: RTL

Load/store request initiator that drives the data memory's single read/write port. Sits between the load/store queue and the data memory. Accepts one memory operation at a time, issues it with the cache-miss qualifier asserted, and tracks it to completion. Loads complete on the memory's delayed valid; stores complete after a fixed latency count. Returns a tagged result to the common data bus. While an operation is in flight it back-pressures the queue, which enforces the memory's single-outstanding-request rule.

---
 rtl/lsu_mem_req_if.sv | 56 +++++
 rtl/lsu_mem_req.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_req_if.sv
// Bundle of the load/store request, data-memory port and result-bus signals.
// slave is the lsu_mem_req side; master is the queue/memory/bus side.
// Handshake rule for both req_* and resp_*: a transfer happens on a rising edge
// where valid and ready are both high; the sender holds valid and all fields
// stable until that edge, and ready never depends combinationally on valid.
interface lsu_mem_req_if;
    // request from the load/store queue
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [5:0]  req_tag;
    logic [3:0]  req_op;
    // data-memory single read/write port
    logic [31:0] mem_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [5:0]  mem_reg;
    logic [3:0]  mem_op;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic        mem_miss;
    logic [31:0] mem_pc_in;
    logic [5:0]  mem_reg_in;
    logic [31:0] mem_data;
    logic        mem_valid;
    // result toward the common data bus
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_pc;
    logic [31:0] resp_data;
    logic [5:0]  resp_tag;
    logic        resp_is_store;
    logic        resp_err;

    modport slave (
        input  req_valid, req_pc, req_addr, req_wdata, req_tag, req_op,
        output req_ready,
        output mem_pc, mem_addr, mem_wdata, mem_reg, mem_op,
        output mem_rd_en, mem_wr_en, mem_miss,
        input  mem_pc_in, mem_reg_in, mem_data, mem_valid,
        output resp_valid, resp_pc, resp_data, resp_tag, resp_is_store, resp_err,
        input  resp_ready
    );

    modport master (
        output req_valid, req_pc, req_addr, req_wdata, req_tag, req_op,
        input  req_ready,
        input  mem_pc, mem_addr, mem_wdata, mem_reg, mem_op,
        input  mem_rd_en, mem_wr_en, mem_miss,
        output mem_pc_in, mem_reg_in, mem_data, mem_valid,
        input  resp_valid, resp_pc, resp_data, resp_tag, resp_is_store, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/lsu_mem_req.sv
// Load/store request initiator for the data memory's single read/write port.
// One operation in flight at a time: accept in IDLE, strobe the port for one
// cycle in ISSUE, wait for load data or a fixed store latency in WAIT, then
// hold the tagged result in RESP until the bus takes it.
// Optional feature macro: LSU_TIMEOUT_EN adds a load watchdog that ends a
// load with resp_err after TIMEOUT WAIT cycles without a matching return.
module lsu_mem_req #(
    parameter int unsigned MEM_LATENCY = 10,
    parameter int unsigned TIMEOUT     = 31
) (
    input  logic               clk,
    input  logic               rstn,
    lsu_mem_req_if.slave       bus,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] OP_LB = 4'd7;
    localparam logic [3:0] OP_LW = 4'd8;
    localparam logic [3:0] OP_SB = 4'd9;
    localparam logic [3:0] OP_SW = 4'd10;

    localparam logic [7:0] LAT_LAST = 8'(MEM_LATENCY - 1);
`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
`endif

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [5:0]  r_tag;
    logic [3:0]  r_op;
    logic [7:0]  r_cnt;
    logic [31:0] r_resp_data;
    logic        r_resp_err;
    logic        r_resp_is_store;

    logic        w_req_legal;
    logic        w_is_load;
    logic        w_match;
    logic [7:0]  w_cnt_inc;
    logic        w_accept;
    logic        w_load_done;
    logic        w_store_done;
`ifdef LSU_TIMEOUT_EN
    logic        w_timeout;
`endif

    assign w_req_legal = (bus.req_op == OP_LB) || (bus.req_op == OP_LW) ||
                         (bus.req_op == OP_SB) || (bus.req_op == OP_SW);
    assign w_is_load   = (r_op == OP_LB) || (r_op == OP_LW);
    assign w_match     = bus.mem_valid && (bus.mem_reg_in == r_tag) &&
                         (bus.mem_pc_in == r_pc);
    // Saturating increment; the latency and watchdog compares look at the
    // value being loaded this edge, so the store result lands MEM_LATENCY
    // cycles after the strobe cycle.
    assign w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : (r_cnt + 8'd1);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle completion events.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load_done  = 1'b0;
        w_store_done = 1'b0;
`ifdef LSU_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_req_legal ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_is_load) begin
                    // A matching return wins over a watchdog expiry in the same cycle.
                    if (w_match) begin
                        w_load_done  = 1'b1;
                        w_state_next = S_RESP;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (w_cnt_inc == TO_LIMIT) begin
                        w_timeout    = 1'b1;
                        w_state_next = S_RESP;
                    end
`endif
                end else if (w_cnt_inc == LAT_LAST) begin
                    w_store_done = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request latch, wait counter and result capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc            <= '0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_tag           <= '0;
            r_op            <= '0;
            r_cnt           <= '0;
            r_resp_data     <= '0;
            r_resp_err      <= 1'b0;
            r_resp_is_store <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pc            <= bus.req_pc;
                r_addr          <= bus.req_addr;
                r_wdata         <= bus.req_wdata;
                r_tag           <= bus.req_tag;
                r_op            <= bus.req_op;
                r_cnt           <= '0;
                r_resp_data     <= '0;
                r_resp_err      <= !w_req_legal;
                r_resp_is_store <= 1'b0;
            end
            if (r_state == S_WAIT) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_load_done) begin
                r_resp_data <= (r_op == OP_LB) ? {24'b0, bus.mem_data[7:0]} : bus.mem_data;
            end
            if (w_store_done) begin
                r_resp_is_store <= 1'b1;
            end
`ifdef LSU_TIMEOUT_EN
            if (w_timeout) begin
                r_resp_err <= 1'b1;
            end
`endif
        end
    end

    assign bus.req_ready     = (r_state == S_IDLE);
    assign bus.mem_pc        = r_pc;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wdata     = r_wdata;
    assign bus.mem_reg       = r_tag;
    assign bus.mem_op        = r_op;
    assign bus.mem_rd_en     = (r_state == S_ISSUE) && w_is_load;
    assign bus.mem_wr_en     = (r_state == S_ISSUE) && !w_is_load;
    assign bus.mem_miss      = (r_state == S_ISSUE);
    assign bus.resp_valid    = (r_state == S_RESP);
    assign bus.resp_pc       = r_pc;
    assign bus.resp_data     = r_resp_data;
    assign bus.resp_tag      = r_tag;
    assign bus.resp_is_store = r_resp_is_store;
    assign bus.resp_err      = r_resp_err;
    assign o_dbg_state       = r_state;

endmodule
